// File: rtl/pim_sched_pkg.sv
// Shared types for the PIM job scheduler: mode encoding, job descriptor, FSM states.
// No logic of its own; legality helper is purely combinational.
package pim_sched_pkg;

  typedef enum logic [2:0] {
    MODE_READ    = 3'd1,
    MODE_PROGRAM = 3'd2,
    MODE_ERASE   = 3'd3,
    MODE_COMPUTE = 3'd4
  } pim_mode_e;

  typedef struct packed {
    pim_mode_e   mode;
    logic [6:0]  row;
    logic [8:0]  col;
    logic [3:0]  exec;
  } job_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COOL
  } sched_state_e;

  function automatic logic mode_legal(input pim_mode_e m);
    return (m == MODE_READ) || (m == MODE_PROGRAM) ||
           (m == MODE_ERASE) || (m == MODE_COMPUTE);
  endfunction

endpackage

// File: rtl/pim_job_fifo.sv
// Synchronous descriptor FIFO; head visible combinationally, pop/push take effect next edge.
// Push ignored when full, pop ignored when empty; flush empties it and wins over push/pop.
module pim_job_fifo
  import pim_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  job_desc_t                wr_dat,
  output job_desc_t                rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  job_desc_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count < PW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/pim_job_scheduler.sv
// Issues queued PIM jobs one at a time: pim_en_o 2 cycles after a push into an idle block,
// then waits for done/timeout plus GAP_CYC cooldown; cmd_ready_o drops while the queue is full.
module pim_job_scheduler
  import pim_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_mode_i,
  input  logic [6:0]               cmd_row_i,
  input  logic [8:0]               cmd_col_i,
  input  logic [3:0]               cmd_exec_i,
  input  logic                     abort_i,
  input  logic                     pim_done_i,
  output logic                     pim_en_o,
  output logic [2:0]               pim_mode_o,
  output logic [6:0]               row_addr7_o,
  output logic [8:0]               col_addr9_o,
  output logic [3:0]               exec_cnt_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic [7:0]               done_cnt_o,
  output logic                     err_timeout_o,
  output logic                     err_illegal_o,
  input  logic                     err_clr_i
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int CW = (TW > GW) ? TW : GW;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  sched_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pim_en_q;
  job_desc_t       desc_q;
  logic [7:0]      done_cnt_q;
  logic            err_to_q, err_il_q;

  job_desc_t       wr_desc, head;
  logic [PW-1:0]   count;
  logic            push, pop, nonempty, head_legal;
  logic            start_issue, set_to, set_il, job_done;

  assign wr_desc = '{mode: pim_mode_e'(cmd_mode_i), row: cmd_row_i,
                     col: cmd_col_i, exec: cmd_exec_i};
  assign cmd_ready_o = (count < PW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o && !abort_i;
  assign nonempty    = (count != '0);
  assign head_legal  = mode_legal(head.mode);

  pim_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (push),
    .pop    (pop),
    .flush  (abort_i),
    .wr_dat (wr_desc),
    .rd_dat (head),
    .count  (count)
  );

  // The counter is shared: it times the WAIT window and the cooldown gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    start_issue = 1'b0;
    set_to      = 1'b0;
    set_il      = 1'b0;
    job_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nonempty) begin
          state_d     = ST_ISSUE;
          start_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        pop   = 1'b1;
        cnt_d = '0;
        if (head_legal) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_COOL;
          set_il  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (pim_done_i) begin
          job_done = 1'b1;
          state_d  = ST_COOL;
          cnt_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          set_to  = 1'b1;
          state_d = ST_COOL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COOL: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (nonempty) begin
            state_d     = ST_ISSUE;
            start_issue = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      pop         = 1'b0;
      start_issue = 1'b0;
      set_to      = 1'b0;
      set_il      = 1'b0;
      job_done    = 1'b0;
    end
  end

  // Strobe and descriptor are loaded on the edge entering ISSUE so they line up in that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pim_en_q   <= 1'b0;
      desc_q     <= '0;
      done_cnt_q <= '0;
      err_to_q   <= 1'b0;
      err_il_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pim_en_q <= start_issue && head_legal;
      if (start_issue && head_legal) desc_q <= head;
      if (job_done) done_cnt_q <= done_cnt_q + 8'd1;
      if (err_clr_i) begin
        err_to_q <= 1'b0;
        err_il_q <= 1'b0;
      end else begin
        if (set_to) err_to_q <= 1'b1;
        if (set_il) err_il_q <= 1'b1;
      end
    end
  end

  assign pim_en_o      = pim_en_q;
  assign pim_mode_o    = desc_q.mode;
  assign row_addr7_o   = desc_q.row;
  assign col_addr9_o   = desc_q.col;
  assign exec_cnt_o    = desc_q.exec;
  assign busy_o        = (state_q != ST_IDLE) || nonempty;
  assign pending_o     = count;
  assign done_cnt_o    = done_cnt_q;
  assign err_timeout_o = err_to_q;
  assign err_illegal_o = err_il_q;

endmodule

// File: tb/tb_pim_job_scheduler.sv
// Bench for pim_job_scheduler: timestamp-based job model checked every cycle,
// plus hand-computed latency/gap/status expectations for the directed scenarios.
module tb_pim_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 1023;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [2:0] cmd_mode_i = '0;
  logic [6:0] cmd_row_i = '0;
  logic [8:0] cmd_col_i = '0;
  logic [3:0] cmd_exec_i = '0;
  logic       abort_i = 1'b0;
  logic       pim_done_i = 1'b0;
  logic       pim_en_o;
  logic [2:0] pim_mode_o;
  logic [6:0] row_addr7_o;
  logic [8:0] col_addr9_o;
  logic [3:0] exec_cnt_o;
  logic       busy_o;
  logic [2:0] pending_o;
  logic [7:0] done_cnt_o;
  logic       err_timeout_o;
  logic       err_illegal_o;
  logic       err_clr_i = 1'b0;

  pim_job_scheduler #(.DEPTH(DEPTH), .GAP_CYC(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_mode_i(cmd_mode_i), .cmd_row_i(cmd_row_i), .cmd_col_i(cmd_col_i),
    .cmd_exec_i(cmd_exec_i), .abort_i(abort_i), .pim_done_i(pim_done_i),
    .pim_en_o(pim_en_o), .pim_mode_o(pim_mode_o), .row_addr7_o(row_addr7_o),
    .col_addr9_o(col_addr9_o), .exec_cnt_o(exec_cnt_o), .busy_o(busy_o),
    .pending_o(pending_o), .done_cnt_o(done_cnt_o),
    .err_timeout_o(err_timeout_o), .err_illegal_o(err_illegal_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int mode;
    int row;
    int col;
    int ex;
  } job_t;

  job_t m_q[$];
  job_t m_desc;
  int   m_issue_at  = -1;   // cycle in which the head is being issued
  int   m_wait_from = -1;   // first cycle the in-flight job waits for done
  int   m_cool_last = -1;   // last cycle of the post-job gap
  int   m_done = 0;
  bit   m_eto = 0, m_eil = 0;

  int   sz;
  bit   ex_issue, ex_en, ex_busy, free_now, set_to, set_il;
  job_t hd;

  function automatic bit legal(input int m);
    return (m >= 1) && (m <= 4);
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      m_q.delete();
      m_issue_at  = -1;
      m_wait_from = -1;
      m_cool_last = -1;
      m_done = 0;
      m_eto  = 0;
      m_eil  = 0;
      m_desc = '{mode: 0, row: 0, col: 0, ex: 0};
    end
    ex_issue = (m_issue_at == cyc);
    ex_en    = ex_issue && (m_q.size() > 0) && legal(m_q[0].mode);
    ex_busy  = ex_issue || (m_wait_from >= 0) || (cyc <= m_cool_last) || (m_q.size() > 0);
    chk("cmd_ready", cmd_ready_o, m_q.size() < DEPTH);
    chk("pending", pending_o, m_q.size());
    chk("busy", busy_o, ex_busy);
    chk("pim_en", pim_en_o, ex_en);
    chk("pim_mode", pim_mode_o, m_desc.mode);
    chk("row", row_addr7_o, m_desc.row);
    chk("col", col_addr9_o, m_desc.col);
    chk("exec", exec_cnt_o, m_desc.ex);
    chk("done_cnt", done_cnt_o, m_done);
    chk("err_timeout", err_timeout_o, m_eto);
    chk("err_illegal", err_illegal_o, m_eil);

    if (!rst_i) begin
      set_to = 0;
      set_il = 0;
      if (abort_i) begin
        m_q.delete();
        m_issue_at  = -1;
        m_wait_from = -1;
        m_cool_last = -1;
      end else begin
        sz = m_q.size();
        free_now = !ex_issue && (m_wait_from < 0) && (cyc >= m_cool_last);
        if (ex_issue) begin
          hd = m_q.pop_front();
          m_issue_at = -1;
          if (legal(hd.mode)) m_wait_from = cyc + 1;
          else begin
            set_il = 1;
            m_cool_last = cyc + GAP;
          end
        end else if (m_wait_from >= 0) begin
          if (pim_done_i) begin
            m_done = (m_done + 1) % 256;
            m_wait_from = -1;
            m_cool_last = cyc + GAP;
          end else if (cyc - m_wait_from + 1 == TIMEOUT) begin
            set_to = 1;
            m_wait_from = -1;
            m_cool_last = cyc + GAP;
          end
        end
        if (free_now && sz > 0) begin
          m_issue_at = cyc + 1;
          if (legal(m_q[0].mode)) m_desc = m_q[0];
        end
        if (cmd_valid_i && sz < DEPTH)
          m_q.push_back('{mode: int'(cmd_mode_i), row: int'(cmd_row_i),
                         col: int'(cmd_col_i), ex: int'(cmd_exec_i)});
      end
      if (err_clr_i) begin
        m_eto = 0;
        m_eil = 0;
      end else begin
        if (set_to) m_eto = 1;
        if (set_il) m_eil = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_job(input int mode, input int row, input int col, input int ex,
                          output int t);
    cmd_mode_i  = 3'(mode);
    cmd_row_i   = 7'(row);
    cmd_col_i   = 9'(col);
    cmd_exec_i  = 4'(ex);
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 200 && !cmd_ready_o; k++) step();
    chk("push_ready_budget", cmd_ready_o, 1);
    t = cyc;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_en(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (pim_en_o) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic serve(input int n);
    int at, d;
    d = 0;
    for (int k = 0; k < n; k++) begin
      wait_en(2000, at);
      if (k > 0) chk("t2_gap", at, d + 3);
      step();
      pim_done_i = 1'b1;
      d = cyc;
      step();
      pim_done_i = 1'b0;
    end
  endtask

  task automatic finish_job();
    step();
    pim_done_i = 1'b1;
    step();
    pim_done_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, t5, tmp, at, at2, i;

    // 1. reset values, then a single READ job
    repeat (3) step();
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_pending", pending_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_en", pim_en_o, 0);
    chk("rst_done", done_cnt_o, 0);
    rst_i = 1'b0;
    repeat (2) step();
    push_job(1, 5, 17, 3, t);
    chk("t1_pending_1", pending_o, 1);
    wait_en(10, at);
    chk("t1_latency", at, t + 2);
    chk("t1_mode", pim_mode_o, 1);
    chk("t1_row", row_addr7_o, 5);
    chk("t1_col", col_addr9_o, 17);
    chk("t1_exec", exec_cnt_o, 3);
    step();
    chk("t1_pending_0", pending_o, 0);
    pim_done_i = 1'b1;
    step();
    pim_done_i = 1'b0;
    chk("t1_done_cnt", done_cnt_o, 1);
    repeat (4) step();

    // 2. back-to-back pushes overfill the queue while jobs are served
    fork
      begin
        push_job(2, 10, 100, 1, t0);
        push_job(3, 11, 101, 2, tmp);
        push_job(4, 12, 102, 4, tmp);
        push_job(1, 13, 103, 8, tmp);
        push_job(2, 14, 104, 9, tmp);
        push_job(3, 15, 105, 15, t5);
      end
      serve(6);
    join
    chk("t2_sixth_stall", t5, t0 + 7);
    step();
    chk("t2_done_cnt", done_cnt_o, 7);
    repeat (4) step();

    // 3. timeout on a job with no completion; queue keeps going
    push_job(4, 33, 200, 15, tmp);
    wait_en(10, i);
    step();
    push_job(1, 1, 2, 3, tmp);
    at = -1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk_i);
      if (err_timeout_o) begin
        at = cyc;
        break;
      end
    end
    chk("t3_timeout_at", at, i + 1024);
    wait_en(10, at2);
    chk("t3_next_issue", at2, i + 1026);
    finish_job();
    chk("t3_sticky", err_timeout_o, 1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t3_cleared", err_timeout_o, 0);
    repeat (4) step();

    // 4. illegal mode is skipped and flagged, the next job follows after the gap
    push_job(7, 40, 41, 5, t);
    push_job(4, 9, 9, 9, tmp);
    wait_en(10, at);
    chk("t4_issue_at", at, t + 5);
    chk("t4_err_illegal", err_illegal_o, 1);
    chk("t4_mode", pim_mode_o, 4);
    finish_job();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("t4_cleared", err_illegal_o, 0);
    repeat (4) step();

    // 5. abort in WAIT with three queued jobs; same-cycle push and late done are ignored
    push_job(3, 77, 300, 6, tmp);
    wait_en(10, at);
    step();
    push_job(1, 20, 21, 1, tmp);
    push_job(2, 22, 23, 2, tmp);
    push_job(4, 24, 25, 3, tmp);
    chk("t5_pending_3", pending_o, 3);
    cmd_mode_i  = 3'd2;
    cmd_row_i   = 7'd99;
    cmd_valid_i = 1'b1;
    abort_i     = 1'b1;
    step();
    abort_i     = 1'b0;
    cmd_valid_i = 1'b0;
    chk("t5_pending_0", pending_o, 0);
    chk("t5_busy_0", busy_o, 0);
    pim_done_i = 1'b1;
    step();
    pim_done_i = 1'b0;
    step();
    chk("t5_done_unchanged", done_cnt_o, 9);
    chk("t5_row_held", row_addr7_o, 77);
    repeat (3) step();

    // 6. asynchronous reset mid-WAIT and mid-cooldown, then normal operation
    push_job(2, 50, 51, 7, tmp);
    wait_en(10, at);
    step();
    rst_i = 1'b1;
    #1;
    chk("t6a_busy", busy_o, 0);
    chk("t6a_done", done_cnt_o, 0);
    chk("t6a_row", row_addr7_o, 0);
    chk("t6a_ready", cmd_ready_o, 1);
    step();
    rst_i = 1'b0;
    step();
    push_job(3, 60, 61, 2, tmp);
    wait_en(10, at);
    finish_job();
    rst_i = 1'b1;
    #1;
    chk("t6b_busy", busy_o, 0);
    chk("t6b_done", done_cnt_o, 0);
    chk("t6b_mode", pim_mode_o, 0);
    step();
    rst_i = 1'b0;
    step();
    push_job(1, 5, 17, 3, t);
    wait_en(10, at);
    chk("t6_latency", at, t + 2);
    chk("t6_row", row_addr7_o, 5);
    finish_job();
    chk("t6_done_cnt", done_cnt_o, 1);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
